// File: rtl/mxv_pkg.sv
// ---------------------------------------------------------------------------
// mxv_pkg
// Shared constants and types for the MxV accelerator's UART-side logic.
//   DW          byte width
//   LEN_W       width of the requested-length field (frm_len)
//   MAX_LEN     maximum payload bytes per response frame
//   FRAME_HDR   first byte of every response frame
//   FRAME_TAIL  last byte of every response frame
//   frm_state_t framer FSM states
//   hs_state_t  per-byte UART handshake states
// Optional build macro: MXV_FRAME_CHECKSUM_EN adds the SEND_CHK state.
// ---------------------------------------------------------------------------
package mxv_pkg;

    localparam int DW      = 8;
    localparam int LEN_W   = 5;
    localparam int MAX_LEN = 16;

    localparam logic [DW-1:0] FRAME_HDR  = 8'hFE;
    localparam logic [DW-1:0] FRAME_TAIL = 8'hEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_LEN,
        ST_SEND_CMD,
        ST_PAY_WAIT,
        ST_SEND_PAY,
`ifdef MXV_FRAME_CHECKSUM_EN
        ST_SEND_CHK,
`endif
        ST_SEND_TAIL
    } frm_state_t;

    typedef enum logic [1:0] {
        HS_ISSUE,
        HS_WAIT_HI,
        HS_WAIT_LO
    } hs_state_t;

    // Requests longer than the frame can carry are truncated to MAX_LEN.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/mxv_frame_tx_if.sv
// ---------------------------------------------------------------------------
// mxv_frame_tx_if
// Bundles the three sides of the response framer:
//   frame request : frm_start, frm_cmd, frm_len -> frm_busy, frm_done, len_err
//   result stream : res_valid, res_data -> res_ready
//   UART transmit : tx_start, tx_data <- tx_busy
// Modports: slave  = the framer itself
//           master = the environment (result path + UART)
// ---------------------------------------------------------------------------
interface mxv_frame_tx_if;
    import mxv_pkg::*;

    logic             frm_start;
    logic [DW-1:0]    frm_cmd;
    logic [LEN_W-1:0] frm_len;
    logic             frm_busy;
    logic             frm_done;
    logic             len_err;

    logic             res_valid;
    logic [DW-1:0]    res_data;
    logic             res_ready;

    logic             tx_start;
    logic [DW-1:0]    tx_data;
    logic             tx_busy;

    modport slave (
        input  frm_start, frm_cmd, frm_len, res_valid, res_data, tx_busy,
        output frm_busy, frm_done, len_err, res_ready, tx_start, tx_data
    );

    modport master (
        output frm_start, frm_cmd, frm_len, res_valid, res_data, tx_busy,
        input  frm_busy, frm_done, len_err, res_ready, tx_start, tx_data
    );

endinterface

// File: rtl/mxv_tx_byte_hs.sv
// ---------------------------------------------------------------------------
// mxv_tx_byte_hs
// Sends one byte to the UART transmitter per request.
//   clk, rst  clock, synchronous active-high reset
//   byte_req  framer wants byte_in sent
//   byte_in   byte to send (captured at issue)
//   byte_ack  combinational; high in the cycle tx_busy is seen low again
//   tx_start  registered one-cycle Transmit pulse
//   tx_data   registered Data_In, stable until the byte completes
//   tx_busy   UART busy
// ---------------------------------------------------------------------------
module mxv_tx_byte_hs
    import mxv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          byte_req,
    input  logic [DW-1:0] byte_in,
    output logic          byte_ack,
    output logic          tx_start,
    output logic [DW-1:0] tx_data,
    input  logic          tx_busy
);

    hs_state_t state, state_nxt;
    logic      issue;

    always_ff @(posedge clk) begin
        if (rst) state <= HS_ISSUE;
        else     state <= state_nxt;
    end

    // Issue only while the UART is idle; the ack is combinational so the
    // framer leaves its state on the same edge we return to ISSUE, which
    // keeps the just-finished byte from being sent twice.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        byte_ack  = 1'b0;
        case (state)
            HS_ISSUE: begin
                if (byte_req && !tx_busy) begin
                    issue     = 1'b1;
                    state_nxt = HS_WAIT_HI;
                end
            end
            HS_WAIT_HI: begin
                if (tx_busy) state_nxt = HS_WAIT_LO;
            end
            HS_WAIT_LO: begin
                if (!tx_busy) begin
                    byte_ack  = 1'b1;
                    state_nxt = HS_ISSUE;
                end
            end
            default: state_nxt = HS_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= issue;
            if (issue) tx_data <= byte_in;
        end
    end

endmodule

// File: rtl/mxv_frame_tx.sv
// ---------------------------------------------------------------------------
// mxv_frame_tx
// Response framer: HDR, LEN, CMD, payload[0..n-1], TAIL to the UART.
//   clk  divided UART-domain clock
//   rst  synchronous active-high reset, aborts any frame in progress
//   bus  mxv_frame_tx_if.slave (frame request, result stream, UART side)
// Optional build macro: MXV_FRAME_CHECKSUM_EN inserts an XOR checksum byte
// (over LEN, CMD and payload) before TAIL; LEN does not count it.
// ---------------------------------------------------------------------------
module mxv_frame_tx
    import mxv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mxv_frame_tx_if.slave   bus
);

`ifdef MXV_FRAME_CHECKSUM_EN
    localparam frm_state_t AFTER_DATA = ST_SEND_CHK;
`else
    localparam frm_state_t AFTER_DATA = ST_SEND_TAIL;
`endif

    frm_state_t       state, state_nxt;
    logic [DW-1:0]    cmd_q;
    logic [DW-1:0]    pay_q;
    logic [LEN_W-1:0] n_q;
    logic [LEN_W-1:0] pay_cnt;
    logic             frm_done_q;
    logic             len_err_q;
    logic [DW-1:0]    len_byte;
    logic             accept;
    logic             pay_take;
    logic             pay_last;
    logic             byte_req;
    logic             byte_ack;
    logic [DW-1:0]    byte_in;
    logic             tx_start_w;
    logic [DW-1:0]    tx_data_w;
`ifdef MXV_FRAME_CHECKSUM_EN
    logic [DW-1:0]    chk_q;
`endif

    // LEN counts the CMD byte plus the payload.
    assign len_byte = DW'(n_q) + DW'(1);
    assign accept   = (state == ST_IDLE) && bus.frm_start;
    assign pay_take = (state == ST_PAY_WAIT) && bus.res_valid;
    assign pay_last = (pay_cnt == n_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        byte_req  = 1'b0;
        byte_in   = FRAME_HDR;
        case (state)
            ST_IDLE: begin
                if (bus.frm_start) state_nxt = ST_SEND_HDR;
            end
            ST_SEND_HDR: begin
                byte_req = 1'b1;
                byte_in  = FRAME_HDR;
                if (byte_ack) state_nxt = ST_SEND_LEN;
            end
            ST_SEND_LEN: begin
                byte_req = 1'b1;
                byte_in  = len_byte;
                if (byte_ack) state_nxt = ST_SEND_CMD;
            end
            ST_SEND_CMD: begin
                byte_req = 1'b1;
                byte_in  = cmd_q;
                if (byte_ack) state_nxt = (n_q != '0) ? ST_PAY_WAIT : AFTER_DATA;
            end
            ST_PAY_WAIT: begin
                if (bus.res_valid) state_nxt = ST_SEND_PAY;
            end
            ST_SEND_PAY: begin
                byte_req = 1'b1;
                byte_in  = pay_q;
                if (byte_ack) state_nxt = pay_last ? AFTER_DATA : ST_PAY_WAIT;
            end
`ifdef MXV_FRAME_CHECKSUM_EN
            ST_SEND_CHK: begin
                byte_req = 1'b1;
                byte_in  = chk_q;
                if (byte_ack) state_nxt = ST_SEND_TAIL;
            end
`endif
            ST_SEND_TAIL: begin
                byte_req = 1'b1;
                byte_in  = FRAME_TAIL;
                if (byte_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame context is captured once at acceptance so the requester may
    // change frm_cmd/frm_len while the frame is still going out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            pay_q      <= '0;
            n_q        <= '0;
            pay_cnt    <= '0;
            frm_done_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            frm_done_q <= (state == ST_SEND_TAIL) && byte_ack;
            len_err_q  <= accept && (bus.frm_len > LEN_W'(MAX_LEN));
            if (accept) begin
                cmd_q   <= bus.frm_cmd;
                n_q     <= clamp_len(bus.frm_len);
                pay_cnt <= '0;
            end
            if (pay_take) pay_q <= bus.res_data;
            if ((state == ST_SEND_PAY) && byte_ack) pay_cnt <= pay_cnt + LEN_W'(1);
        end
    end

`ifdef MXV_FRAME_CHECKSUM_EN
    // Folds each LEN, CMD and payload byte in as it completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= '0;
        end else if (accept) begin
            chk_q <= '0;
        end else if (byte_ack && ((state == ST_SEND_LEN) || (state == ST_SEND_CMD) ||
                                  (state == ST_SEND_PAY))) begin
            chk_q <= chk_q ^ byte_in;
        end
    end
`endif

    mxv_tx_byte_hs u_hs (
        .clk      (clk),
        .rst      (rst),
        .byte_req (byte_req),
        .byte_in  (byte_in),
        .byte_ack (byte_ack),
        .tx_start (tx_start_w),
        .tx_data  (tx_data_w),
        .tx_busy  (bus.tx_busy)
    );

    assign bus.tx_start  = tx_start_w;
    assign bus.tx_data   = tx_data_w;
    assign bus.frm_busy  = (state != ST_IDLE);
    assign bus.frm_done  = frm_done_q;
    assign bus.len_err   = len_err_q;
    assign bus.res_ready = (state == ST_PAY_WAIT);

endmodule

// File: tb/tb_mxv_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_mxv_frame_tx
// Drives mxv_frame_tx with a UART model (fixed or random busy time) and a
// payload source with optional gaps, and compares every transmitted byte
// against a frame built directly from the framing rules.
// Honours MXV_FRAME_CHECKSUM_EN when building expected frames.
// ---------------------------------------------------------------------------
module tb_mxv_frame_tx;
    import mxv_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mxv_frame_tx_if bus ();

    mxv_frame_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // UART model / monitor state
    logic [7:0] cap_q[$];
    int         uart_len = 10;
    int         viol_cnt = 0;
    int         dstab_cnt = 0;
    int         done_cnt = 0;
    int         lerr_cnt = 0;
    int         rdy_cnt = 0;
    int         stall_tx_cnt = 0;
    int         idle_tx_cnt = 0;

    // Payload source state
    logic [7:0] src_q[$];
    logic [7:0] acc_q[$];
    int         gap_len = 0;
    int         gap_left = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART: captures the byte on tx_start, stays busy for a while, flags any
    // tx_start during busy and any change of tx_data while the byte is out.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                logic [7:0] b;
                int         nb;
                b  = bus.tx_data;
                cap_q.push_back(b);
                bus.tx_busy = 1'b1;
                nb = (uart_len == 0) ? int'($urandom_range(3, 12)) : uart_len;
                repeat (nb) begin
                    @(negedge clk);
                    if (bus.tx_start) viol_cnt++;
                    if (bus.tx_data !== b) dstab_cnt++;
                end
                bus.tx_busy = 1'b0;
            end
        end
    end

    // Payload source: presents src_q in order; after each accepted byte holds
    // res_valid low for gap_len cycles (random 0..3 when gap_len < 0).
    initial begin
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        forever begin
            @(negedge clk);
            if (src_q.size() > 0 && gap_left == 0) begin
                bus.res_valid = 1'b1;
                bus.res_data  = src_q[0];
            end else begin
                bus.res_valid = 1'b0;
                if (gap_left > 0) gap_left--;
            end
            if (bus.res_valid && bus.res_ready) begin
                acc_q.push_back(bus.res_data);
                void'(src_q.pop_front());
                gap_left = (gap_len >= 0) ? gap_len : int'($urandom_range(0, 3));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.frm_done) done_cnt++;
            if (bus.len_err) lerr_cnt++;
            if (bus.res_ready) rdy_cnt++;
            if (bus.res_ready && bus.tx_start) stall_tx_cnt++;
            if (bus.tx_start && !bus.frm_busy) idle_tx_cnt++;
        end
    end

    task automatic waitUartIdle();
        int t = 0;
        @(negedge clk);
        while (bus.tx_busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        checkOutput("uart_idle", 32'(bus.tx_busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tx_start"},  32'(bus.tx_start),  32'd0);
        checkOutput({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
        checkOutput({tag, "_frm_busy"},  32'(bus.frm_busy),  32'd0);
        checkOutput({tag, "_frm_done"},  32'(bus.frm_done),  32'd0);
        checkOutput({tag, "_len_err"},   32'(bus.len_err),   32'd0);
        checkOutput({tag, "_res_ready"}, 32'(bus.res_ready), 32'd0);
    endtask

    // One complete frame: build expected bytes, request, check start timing,
    // optionally poke a second frm_start mid-frame, then compare everything.
    task automatic applyStimulus(input logic [7:0] cmd, input int len, input bit fixed_pay,
                                 input int gap, input bit poke);
        logic [7:0] exp_q[$];
        logic [7:0] pay[$];
        logic [7:0] chk;
        int         n;
        int         t;
        logic [31:0] got;

        waitUartIdle();
        n = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = 0; i < n; i++)
            pay.push_back(fixed_pay ? 8'((i + 1) * 17) : 8'($urandom));

        exp_q = {};
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'(n + 1));
        exp_q.push_back(cmd);
        chk = 8'(n + 1) ^ cmd;
        foreach (pay[i]) begin
            exp_q.push_back(pay[i]);
            chk ^= pay[i];
        end
`ifdef MXV_FRAME_CHECKSUM_EN
        exp_q.push_back(chk);
`endif
        exp_q.push_back(8'hEF);

        src_q = pay;
        acc_q = {};
        cap_q = {};
        gap_len = gap;
        gap_left = 0;
        viol_cnt = 0; dstab_cnt = 0; done_cnt = 0; lerr_cnt = 0;
        rdy_cnt = 0; stall_tx_cnt = 0; idle_tx_cnt = 0;

        bus.frm_cmd   = cmd;
        bus.frm_len   = 5'(len);
        bus.frm_start = 1'b1;
        @(negedge clk);
        bus.frm_start = 1'b0;
        bus.frm_cmd   = ~cmd;
        bus.frm_len   = 5'($urandom);
        checkOutput("busy_after_start", 32'(bus.frm_busy), 32'd1);
        checkOutput("len_err_pulse", 32'(bus.len_err), 32'(len > MAX_LEN));
        @(negedge clk);
        checkOutput("hdr_latency", 32'(bus.tx_start), 32'd1);
        checkOutput("hdr_data", 32'(bus.tx_data), 32'hFE);

        if (poke) begin
            repeat (5) @(negedge clk);
            bus.frm_cmd   = 8'hAA;
            bus.frm_len   = 5'd3;
            bus.frm_start = 1'b1;
            @(negedge clk);
            bus.frm_start = 1'b0;
        end

        t = 0;
        while (!bus.frm_done && t < 4000) begin
            @(negedge clk);
            t++;
        end
        checkOutput("done_seen", 32'(bus.frm_done), 32'd1);
        checkOutput("busy_at_done", 32'(bus.frm_busy), 32'd0);
        repeat (3) @(negedge clk);

        checkOutput("frame_size", 32'(cap_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            got = (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("byte%0d", i), got, 32'(exp_q[i]));
        end
        checkOutput("pay_accepted", 32'(acc_q.size()), 32'(n));
        foreach (pay[i]) begin
            got = (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("acc%0d", i), got, 32'(pay[i]));
        end
        checkOutput("done_count", 32'(done_cnt), 32'd1);
        checkOutput("len_err_count", 32'(lerr_cnt), 32'(len > MAX_LEN));
        if (n == 0) checkOutput("res_ready_n0", 32'(rdy_cnt), 32'd0);
        checkOutput("tx_in_stall", 32'(stall_tx_cnt), 32'd0);
        checkOutput("tx_while_busy", 32'(viol_cnt), 32'd0);
        checkOutput("tx_data_stable", 32'(dstab_cnt), 32'd0);
        checkOutput("tx_outside_frame", 32'(idle_tx_cnt), 32'd0);
    endtask

    // Starts a frame and resets the DUT once the LEN byte has gone out.
    task automatic applyResetAbort();
        int t = 0;
        waitUartIdle();
        cap_q = {};
        src_q = {8'h55, 8'h66, 8'h77};
        acc_q = {};
        gap_len = 0;
        bus.frm_cmd   = 8'h09;
        bus.frm_len   = 5'd3;
        bus.frm_start = 1'b1;
        @(negedge clk);
        bus.frm_start = 1'b0;
        while (cap_q.size() < 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput("abort_len_sent", 32'(cap_q.size() >= 2), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("abort");
        rst = 1'b0;
        src_q = {};
    endtask

    initial begin
        rst = 1'b1;
        bus.frm_start = 1'b0;
        bus.frm_cmd   = '0;
        bus.frm_len   = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        uart_len = 10;
        applyStimulus(8'h03, 2, 1'b1, 0, 1'b0);
        applyStimulus(8'h05, 0, 1'b0, 0, 1'b0);
        uart_len = 0;
        applyStimulus(8'($urandom), 20, 1'b0, -1, 1'b0);
        uart_len = 10;
        applyStimulus(8'h3C, 4, 1'b0, 30, 1'b1);
        applyResetAbort();
        applyStimulus(8'h03, 2, 1'b1, -1, 1'b0);

        uart_len = 0;
        for (int k = 0; k < 10; k++)
            applyStimulus(8'($urandom), int'($urandom_range(0, 31)), 1'b0, -1, (k % 3) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mxv_frame_tx.md
Name: mxv_frame_tx

Overview:
Response framer for the matrix-by-vector accelerator. It mirrors the byte-level command parser on the receive side. It takes a command code plus a stream of result bytes from the MxV datapath, wraps them in a frame, and hands the frame byte by byte to the UART transmitter through its Transmit/Data_In/busy interface. It sits between the MxV result path and the UART module, on the same divided clock domain.

Parameters:
DW, 8, byte width; matches the DW defined in mxv_pkg.
MAX_LEN, 16, maximum number of payload bytes per frame.
HDR, 8'hFE, frame header byte.
TAIL, 8'hEF, frame tail byte.

Ports:
clk  in  1  system clock (divided UART-domain clock)
rst  in  1  synchronous, active-high reset
frm_start  in  1  request a frame; sampled only in IDLE
frm_cmd  in  DW  command code placed in the CMD byte
frm_len  in  5  number of payload bytes requested (0..31)
frm_busy  out  1  high from the accepted frm_start until frm_done
frm_done  out  1  one-cycle pulse when the TAIL byte completes
len_err  out  1  one-cycle pulse when frm_len > MAX_LEN
res_valid  in  1  payload byte available
res_data  in  DW  payload byte
res_ready  out  1  payload byte accepted when res_valid && res_ready
tx_start  out  1  one-cycle pulse to UART Transmit
tx_data  out  DW  byte to UART Data_In; held stable until that byte completes
tx_busy  in  1  UART transmitter busy

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters cleared. Reset in any state aborts the frame immediately. No partial-frame recovery.
- Frame order: HDR, LEN, CMD, payload[0..n-1], TAIL.
  - n = min(frm_len, MAX_LEN).
  - LEN = n + 1 (the CMD byte plus the payload).
- Frame start:
  - frm_start in IDLE latches frm_cmd and n, and sets frm_busy on the next cycle.
  - If frm_len > MAX_LEN, len_err pulses in that same next cycle and the frame proceeds clamped to MAX_LEN.
  - frm_start while frm_busy=1 is ignored.
- FSM states: IDLE -> SEND_HDR -> SEND_LEN -> SEND_CMD -> (n>0 ? PAY_WAIT -> SEND_PAY, looping n times : skip) -> SEND_TAIL -> IDLE.
- Per-byte handshake (each SEND_* state):
  - ISSUE: when tx_busy=0, drive tx_data and pulse tx_start for exactly one cycle.
  - WAIT_HI: wait for tx_busy=1.
  - WAIT_LO: wait for tx_busy=0. The byte is then complete and the FSM advances on the next cycle.
  - tx_start is never pulsed while tx_busy=1.
- Latency: the HDR tx_start pulse occurs 2 cycles after frm_start, provided tx_busy=0.
- Payload:
  - res_ready=1 only in PAY_WAIT.
  - On res_valid&&res_ready the byte is registered and the FSM moves to SEND_PAY.
  - res_valid low stalls indefinitely; no tx_start is issued while stalled.
- Payload counter counts 0..n-1. The last payload byte is followed by SEND_TAIL.
- frm_done pulses, and frm_busy falls, in the cycle after TAIL's tx_busy falls.
- n=0: frame is HDR, 0x01, CMD, TAIL; res_ready never asserts.

Optional Feature:
MXV_FRAME_CHECKSUM_EN
- Defined: a SEND_CHK state is inserted before SEND_TAIL.
  - It sends an XOR of the LEN byte, the CMD byte and all payload bytes.
  - The accumulator is cleared at frame start.
  - LEN is unchanged; the checksum byte is not counted in LEN.
- Undefined: no SEND_CHK state and no accumulator logic; the frame is exactly as above.

Decomposition:
- mxv_pkg gains:
  - FRAME_HDR and FRAME_TAIL constants;
  - MAX_LEN;
  - an enum typedef for the FSM states;
  - the LEN field width.
- Sub-module mxv_tx_byte_hs: implements ISSUE/WAIT_HI/WAIT_LO against tx_busy. It exposes byte_req/byte_in/byte_ack to the framer FSM.

Test Plan:
- UART model with busy for 10 cycles; frm_cmd=0x03, frm_len=2, payload 0x11,0x22 -> tx bytes FE 03 03 11 22 EF; one frm_done pulse; frm_busy high throughout.
- frm_len=0, frm_cmd=0x05 -> FE 01 05 EF; res_ready stays 0.
- frm_len=20 -> len_err pulses once; exactly 16 payload bytes accepted; LEN byte = 0x11.
- res_valid dropped for 30 cycles between payload bytes -> no tx_start during the gap; byte order preserved. A second frm_start mid-frame is ignored.
- rst asserted after the LEN byte -> all outputs 0 on the next cycle. A subsequent frame is transmitted complete from HDR.
- With MXV_FRAME_CHECKSUM_EN: cmd 0x03, payload 11 22 -> FE 03 03 11 22 33 EF.
